// File: rtl/pc_fetch_stage_pkg.sv
// Shared definitions for the MIPS32 fetch front end: default PCs, the NOP encoding,
// FSM state encodings and the redirect alignment helper.
package pc_fetch_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_stage_if_id_reg.sv
// IF/ID pipeline latch with load, hold and flush; flush beats load, and a flush only
// drops the valid bit so the payload stays available for debug.
module if_id_reg
    import pc_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc_plus4_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic        valid_d,    valid_q;
    logic [31:0] instr_d,    instr_q;
    logic [31:0] pc_d,       pc_q;
    logic [31:0] pc_plus4_d, pc_plus4_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d    = 1'b1;
            instr_d    = instr_in;
            pc_d       = pc_in;
            pc_plus4_d = pc_plus4_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid    = valid_q;
    assign instr    = instr_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// MIPS32 instruction-fetch stage: PC register, boot/run/halt FSM, redirect and stall
// handling. Optional macro PC_ALIGN_CHECK_EN traps misaligned redirects to EXC_VECTOR.
module pc_fetch_stage
    import pc_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic [31:0]      pc_out,
    input  logic [31:0]      pc_plus4_in,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    output logic             if_valid,
    input  logic             id_ready,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_pc_plus4,
    output logic             misalign_exc,
    output logic [CNT_W-1:0] fetch_count
);

    logic [1:0]       state_d,       state_q;
    logic [31:0]      pc_d,          pc_q;
    logic [CNT_W-1:0] fetch_count_d, fetch_count_q;
    logic             misalign_d,    misalign_q;

    logic        fetch_fire;
    logic        slot_free;
    logic [31:0] redirect_pc;
    logic        redirect_bad;

`ifdef PC_ALIGN_CHECK_EN
    assign redirect_bad = is_misaligned(redirect_target);
    assign redirect_pc  = redirect_bad ? EXC_VECTOR : redirect_target;
`else
    assign redirect_bad = 1'b0;
    assign redirect_pc  = redirect_target & ~32'd3;
`endif

    // The slot is free when the latch is empty or decode takes its contents this cycle.
    assign slot_free  = !if_valid || id_ready;
    assign fetch_fire = (state_q == S_RUN) && slot_free && !redirect_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = run ? S_RUN : S_HALT;
            S_RUN:   if (!run) state_d = S_HALT;
            S_HALT:  if (run)  state_d = S_RUN;
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        misalign_d    = 1'b0;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            misalign_d = redirect_bad;
        end else if (fetch_fire) begin
            pc_d          = pc_plus4_in;
            fetch_count_d = fetch_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            misalign_q    <= misalign_d;
        end
    end

    // Outside S_RUN a consumed entry is dropped rather than refilled; a redirect always flushes.
    if_id_reg u_if_id (
        .clk         (clk),
        .rst         (rst),
        .load        (fetch_fire),
        .flush       (redirect_valid || (id_ready && state_q != S_RUN)),
        .instr_in    (imem_rdata),
        .pc_in       (pc_q),
        .pc_plus4_in (pc_plus4_in),
        .valid       (if_valid),
        .instr       (if_instr),
        .pc          (if_pc),
        .pc_plus4    (if_pc_plus4)
    );

    assign pc_out       = pc_q;
    assign fetch_count  = fetch_count_q;
    assign misalign_exc = misalign_q;

endmodule
